// File: rtl/reg_file_dump_reader.sv
// Register file dump reader: walks [start_addr, end_addr] two registers per fetch
// through both read ports and streams {index, value} over a valid/ready interface.
module reg_file_dump_reader #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH-1:0] end_addr,
  output logic [ADDR_WIDTH-1:0] rd_addr_1,
  output logic [ADDR_WIDTH-1:0] rd_addr_2,
  input  logic [DATA_WIDTH-1:0] rd_data_1,
  input  logic [DATA_WIDTH-1:0] rd_data_2,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [1:0] {IDLE, FETCH, SEND} state_t;

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] ptr, end_q, ptr_p1;
  logic [DATA_WIDTH-1:0] slot0_data, slot1_data;
  logic [ADDR_WIDTH-1:0] slot0_addr, slot1_addr;
  logic                  slot1_vld, sel;
  logic                  done_q, err_q;
  logic [DATA_WIDTH-1:0] cur_data;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic                  range_ok, last_slot, cur_is_end;

  assign ptr_p1     = ptr + 1'b1;
  assign range_ok   = (start_addr <= end_addr);
  assign cur_data   = sel ? slot1_data : slot0_data;
  assign cur_addr   = sel ? slot1_addr : slot0_addr;
  assign last_slot  = sel || !slot1_vld;
  assign cur_is_end = (cur_addr == end_q);

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    rd_addr_1  = '0;
    rd_addr_2  = '0;
    out_valid  = 1'b0;
    out_data   = '0;
    out_addr   = '0;
    out_last   = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        if (start && range_ok) state_next = FETCH;
      end
      FETCH: begin
        busy       = 1'b1;
        rd_addr_1  = ptr;
        rd_addr_2  = ptr_p1;
        state_next = SEND;
      end
      SEND: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_data  = cur_data;
        out_addr  = cur_addr;
        out_last  = cur_is_end;
        if (out_ready && last_slot) state_next = cur_is_end ? IDLE : FETCH;
      end
      default: state_next = IDLE;
    endcase
  end

  assign done = done_q;
  assign err  = err_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr        <= '0;
      end_q      <= '0;
      slot0_data <= '0;
      slot0_addr <= '0;
      slot1_data <= '0;
      slot1_addr <= '0;
      slot1_vld  <= 1'b0;
      sel        <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (range_ok) begin
              ptr   <= start_addr;
              end_q <= end_addr;
            end else begin
              done_q <= 1'b1;
              err_q  <= 1'b1;
            end
          end
        end
        FETCH: begin
          slot0_data <= rd_data_1;
          slot0_addr <= ptr;
          slot1_addr <= ptr_p1;
          sel        <= 1'b0;
          // Second port is only kept while still inside the range (also covers ptr wrap at the top).
          if (ptr < end_q) begin
            slot1_data <= rd_data_2;
            slot1_vld  <= 1'b1;
          end else begin
            slot1_vld  <= 1'b0;
          end
        end
        SEND: begin
          if (out_ready) begin
            if (!last_slot)      sel    <= 1'b1;
            else if (cur_is_end) done_q <= 1'b1;
            else                 ptr    <= ptr + ADDR_WIDTH'(2);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
